// File: rtl/link_seq_pkg.sv
// -----------------------------------------------------------------------------
// link_seq_pkg
// Shared definitions for the loopback link sequencer:
//   - seqState_e : frame FSM encoding (also exported on outState)
//   - CRC8_POLY / CRC8_INIT : CRC-8 parameters (x^8+x^2+x+1, init 0)
//   - DEFAULT_FRAME_BITS / DEFAULT_RX_TIMEOUT : default sequencer sizing
//   - crc8Step() : one MSB-first serial CRC-8 update
// -----------------------------------------------------------------------------
package link_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_RX   = 3'd2,
        ST_DONE = 3'd3
    } seqState_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    localparam int DEFAULT_FRAME_BITS = 32;
    localparam int DEFAULT_RX_TIMEOUT = 1024;

    // Serial CRC step: the incoming bit is folded in at the MSB end, so the
    // register holds message * x^8 mod poly after each bit.
    function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic bitIn);
        logic feedback;
        feedback = crc[7] ^ bitIn;
        return {crc[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/link_seq_crc8.sv
// -----------------------------------------------------------------------------
// link_seq_crc8
// Serial CRC-8 (poly 0x07, init 0x00, MSB-first) over captured RX bits.
// Ports:
//   inClock  : system clock
//   inReset  : synchronous active-low reset
//   inClear  : reload the init value (frame start)
//   inEnable : fold inBit into the CRC this cycle
//   inBit    : serial data bit
//   outCrc   : current CRC register
// -----------------------------------------------------------------------------
module link_seq_crc8
    import link_seq_pkg::*;
(
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inClear,
    input  logic       inEnable,
    input  logic       inBit,
    output logic [7:0] outCrc
);

    logic [7:0] crcReg;

    always_ff @(posedge inClock) begin
        if (!inReset) begin
            crcReg <= CRC8_INIT;
        end else if (inClear) begin
            crcReg <= CRC8_INIT;
        end else if (inEnable) begin
            crcReg <= crc8Step(crcReg, inBit);
        end
    end

    assign outCrc = crcReg;

endmodule

// File: rtl/link_sequencer.sv
// -----------------------------------------------------------------------------
// link_sequencer
// Frame controller for the loopback chain
//   inFIFO -> msk_modulator -> decoder_top -> CORDIC -> cdr -> outFIFO.
// Paces inFIFO reads against the modulator ready edge, gates the modulator
// empty input, captures recovered CDR bits into outFIFO and reports per-frame
// done / timeout / overflow status.
//
// Optional build macro: LINK_SEQ_CRC_EN adds outCrc[7:0], a CRC-8 over every
// captured RX bit (including bits dropped for overflow).
//
// Ports:
//   inClock, inReset        : clock, synchronous active-low reset
//   inStart, inAbort        : frame start (IDLE only) / abort to IDLE
//   inTxEmpty, inCoderReady : inFIFO empty, modulator ready
//   outTxReadEnable         : inFIFO read strobe
//   outCoderEmpty           : modulator i_empty
//   inRxFlag, inRxData      : CDR bit strobe and data
//   inRxFull                : outFIFO full
//   outRxWriteEnable        : outFIFO write strobe
//   outRxData               : outFIFO data bit
//   outBusy, outState       : FSM status (outState is the debug encoding)
//   outTxCount, outRxCount  : per-frame bit counters (saturate at FRAME_BITS)
//   outFrameDone, outTimeout: frame-end pulse, timeout qualifier
//   outOverflow             : sticky RX overflow, cleared on start
//   outCrc                  : (LINK_SEQ_CRC_EN only) RX CRC-8
//
// Strobe semantics: inCoderReady is an edge-qualified request (one read per
// 0->1 transition); inRxFlag and both enable outputs are single-cycle strobes
// with no back-pressure -- a write offered while inRxFull=1 is dropped and
// recorded in outOverflow instead of being retried.
// -----------------------------------------------------------------------------
module link_sequencer
    import link_seq_pkg::*;
#(
    parameter int FRAME_BITS = DEFAULT_FRAME_BITS,
    parameter int RX_TIMEOUT = DEFAULT_RX_TIMEOUT,
    parameter int CNT_W      = 8
)(
    input  logic             inClock,
    input  logic             inReset,
    input  logic             inStart,
    input  logic             inAbort,
    input  logic             inTxEmpty,
    input  logic             inCoderReady,
    output logic             outTxReadEnable,
    output logic             outCoderEmpty,
    input  logic             inRxFlag,
    input  logic             inRxData,
    input  logic             inRxFull,
    output logic             outRxWriteEnable,
    output logic             outRxData,
    output logic             outBusy,
    output logic [2:0]       outState,
    output logic [CNT_W-1:0] outTxCount,
    output logic [CNT_W-1:0] outRxCount,
    output logic             outFrameDone,
    output logic             outTimeout,
    output logic             outOverflow
`ifdef LINK_SEQ_CRC_EN
    ,
    output logic [7:0]       outCrc
`endif
);

    localparam int TO_W = $clog2(RX_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(RX_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE     = TO_W'(1);

    seqState_e        state;
    seqState_e        nextState;
    logic             readyPrev;
    logic [CNT_W-1:0] txCount;
    logic [CNT_W-1:0] rxCount;
    logic [TO_W-1:0]  timeoutCount;
    logic             timeoutLatched;
    logic             readEnable;
    logic             writeEnable;
    logic             rxDataReg;
    logic             overflow;

    logic             startFire;
    logic             readFire;
    logic             captureFire;
    logic             timeoutHit;
    logic             rxComplete;

    // ---------------- next-state and event decode ----------------
    always_comb begin
        nextState   = state;
        startFire   = 1'b0;
        readFire    = 1'b0;
        captureFire = 1'b0;
        timeoutHit  = 1'b0;
        rxComplete  = (rxCount == FRAME_LAST);

        if (inAbort) begin
            // Abort outranks everything: no events fire, so pending strobes
            // are never registered and counters hold.
            nextState = ST_IDLE;
        end else begin
            // Capture runs during TX as well: loopback latency means the
            // first bits come back before the last ones are sent.
            captureFire = ((state == ST_TX) || (state == ST_RX)) && inRxFlag && !rxComplete;

            case (state)
                ST_IDLE: begin
                    if (inStart) begin
                        startFire = 1'b1;
                        nextState = ST_TX;
                    end
                end
                ST_TX: begin
                    readFire = inCoderReady && !readyPrev && !inTxEmpty
                               && (txCount != FRAME_LAST);
                    // Leave TX on the same edge that the last read is counted.
                    if (readFire && (txCount == FRAME_LAST - CNT_ONE)) begin
                        nextState = ST_RX;
                    end
                end
                ST_RX: begin
                    // A complete frame wins over a coincident timeout.
                    if (rxComplete) begin
                        nextState = ST_DONE;
                    end else if (timeoutCount == TO_LAST) begin
                        timeoutHit = 1'b1;
                        nextState  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    nextState = ST_IDLE;
                end
                default: begin
                    nextState = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge inClock) begin
        if (!inReset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge inClock) begin
        if (!inReset) begin
            readyPrev      <= 1'b0;
            txCount        <= '0;
            rxCount        <= '0;
            timeoutCount   <= '0;
            timeoutLatched <= 1'b0;
            readEnable     <= 1'b0;
            writeEnable    <= 1'b0;
            rxDataReg      <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            readyPrev   <= inCoderReady;
            readEnable  <= readFire;
            writeEnable <= captureFire && !inRxFull;

            if (startFire) begin
                txCount        <= '0;
                rxCount        <= '0;
                timeoutCount   <= '0;
                timeoutLatched <= 1'b0;
                overflow       <= 1'b0;
            end

            if (readFire) begin
                txCount <= txCount + CNT_ONE;
            end

            if (captureFire) begin
                rxDataReg <= inRxData;
                rxCount   <= rxCount + CNT_ONE;
                if (inRxFull) begin
                    overflow <= 1'b1;
                end
            end

            // Silence timer: only meaningful once all bits have been sent.
            if ((state == ST_RX) && !inAbort) begin
                timeoutCount <= inRxFlag ? '0 : (timeoutCount + TO_ONE);
            end

            if (timeoutHit) begin
                timeoutLatched <= 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign outTxReadEnable  = readEnable;
    assign outRxWriteEnable = writeEnable;
    assign outRxData        = rxDataReg;
    assign outCoderEmpty    = (state == ST_TX) ? inTxEmpty : 1'b1;
    assign outBusy          = (state != ST_IDLE);
    assign outState         = state;
    assign outTxCount       = txCount;
    assign outRxCount       = rxCount;
    assign outFrameDone     = (state == ST_DONE) && !inAbort;
    assign outTimeout       = (state == ST_DONE) && !inAbort && timeoutLatched;
    assign outOverflow      = overflow;

`ifdef LINK_SEQ_CRC_EN
    link_seq_crc8 uCrc (
        .inClock  (inClock),
        .inReset  (inReset),
        .inClear  (startFire),
        .inEnable (captureFire),
        .inBit    (inRxData),
        .outCrc   (outCrc)
    );
`endif

endmodule

// File: doc/link_sequencer.md
Name: link_sequencer

Overview:
Frame-level controller for the loopback chain: inFIFO -> msk_modulator -> decoder_top -> system (CORDIC) -> cdr -> outFIFO.
- On a start command it paces inFIFO reads against the modulator's ready strobe, one bit per ready edge.
- It gates the modulator's empty input and captures recovered CDR bits into outFIFO.
- It counts TX and RX bits per frame and reports done, timeout and overflow status.
- It replaces the ad-hoc read-enable and write-enable muxing used in functional test mode.

Parameters:
FRAME_BITS, 32, bits per frame to transmit and to expect back
RX_TIMEOUT, 1024, cycles without a CDR flag (RX state only) before the frame is abandoned
CNT_W, 8, width of bit counters; must satisfy 2**CNT_W > FRAME_BITS

Ports:
inClock  in  1  system clock
inReset  in  1  reset, synchronous and active-low
inStart  in  1  start-frame pulse; honoured only in IDLE
inAbort  in  1  abort; return to IDLE
inTxEmpty  in  1  inFIFO outEmpty
inCoderReady  in  1  msk_modulator o_ready
outTxReadEnable  out  1  inFIFO read enable, 1-cycle pulse
outCoderEmpty  out  1  msk_modulator i_empty
inRxFlag  in  1  cdr o_flag (1-cycle bit strobe)
inRxData  in  1  cdr o_data
inRxFull  in  1  outFIFO outFull
outRxWriteEnable  out  1  outFIFO write enable, 1-cycle pulse
outRxData  out  1  outFIFO data bit
outBusy  out  1  state != IDLE
outState  out  3  encoded state for the test mux
outTxCount  out  CNT_W  bits read from inFIFO this frame
outRxCount  out  CNT_W  bits captured this frame
outFrameDone  out  1  1-cycle pulse on frame end
outTimeout  out  1  1-cycle pulse, coincident with outFrameDone on timeout end
outOverflow  out  1  sticky; cleared on start or reset

Behaviour:
- Reset (inReset=0 at an inClock edge):
  - state=IDLE; all counters 0.
  - Outputs 0, except outCoderEmpty=1 and outState=3'd0.
- States: IDLE=0, TX=1, RX=2, DONE=3.
- IDLE:
  - outCoderEmpty=1.
  - inStart=1 -> TX next cycle; clears the TX/RX counters, the timeout counter and outOverflow.
- TX:
  - outCoderEmpty = inTxEmpty (combinational, gated by state==TX).
  - A rising edge of inCoderReady (registered previous value 0, current 1) with inTxEmpty=0 drives outTxReadEnable=1 in the following cycle and increments outTxCount.
  - At most one read per ready edge.
  - No read when outTxCount==FRAME_BITS.
  - When outTxCount reaches FRAME_BITS -> RX; outCoderEmpty=1 from that cycle.
  - inTxEmpty=1 mid-frame: wait, no error.
- RX capture (active in TX and RX, because loopback latency overlaps TX):
  - On inRxFlag=1 with outRxCount<FRAME_BITS: next cycle outRxData=registered inRxData and outRxCount increments.
  - If inRxFull=0, outRxWriteEnable=1. If inRxFull=1, no write and outOverflow set.
  - Flags arriving after outRxCount==FRAME_BITS are ignored.
- RX:
  - The timeout counter increments each cycle and clears on inRxFlag.
  - outRxCount==FRAME_BITS -> DONE.
  - Timeout counter == RX_TIMEOUT-1 -> DONE with the timeout flag latched.
  - If both occur in the same cycle, the count wins and there is no timeout.
- DONE:
  - outFrameDone=1 for one cycle; outTimeout=1 in the same cycle if latched.
  - -> IDLE. Counters hold their values until the next start.
- inAbort=1 in any state:
  - IDLE next cycle; pending outTxReadEnable/outRxWriteEnable are suppressed.
  - No outFrameDone; counters hold.
  - Abort has priority over inStart and all other events.
- inStart outside IDLE: ignored.
- Counters saturate at FRAME_BITS and never wrap.

Optional Feature:
LINK_SEQ_CRC_EN:
- Defined:
  - Adds output outCrc[7:0]: CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first.
  - Computed over every captured RX bit, including bits dropped for overflow.
  - Cleared on start; stable from the outFrameDone cycle until the next start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package link_seq_pkg:
  - state enum (IDLE/TX/RX/DONE, 3-bit);
  - CRC8_POLY=8'h07 and CRC8_INIT=8'h00;
  - default FRAME_BITS and RX_TIMEOUT constants.
- Sub-module link_seq_crc8:
  - serial CRC-8 with clear and enable, synchronous active-low reset;
  - instantiated only under LINK_SEQ_CRC_EN.

Test Plan:
- Basic frame: reset, FIFO holding 32 bits, inStart, ready pulses every 8 cycles, CDR flags echoing data -> 32 outTxReadEnable pulses, 32 outRxWriteEnable pulses with matching data, outFrameDone once, outTimeout=0, outTxCount=outRxCount=32.
- Ready held high for 20 cycles -> exactly 1 read pulse, issued the cycle after the rising edge.
- No CDR flags after TX completes -> outTimeout and outFrameDone pulse 1024 cycles after entry to RX; outRxCount=0.
- inRxFull=1 during flags 10-12 -> 29 writes, outOverflow=1 until the next inStart; outRxCount=32.
- inAbort at outTxCount=5 while inRxFlag=1 -> IDLE next cycle, no write or read pulse, no outFrameDone; inStart the same cycle is ignored.
- LINK_SEQ_CRC_EN, RX bits 0xA5 then 24 zero bits (FRAME_BITS=32) -> outCrc equals the reference model value for that bit stream; a second frame starts from 0x00.
